// File: rtl/fifo_word_packer_pkg.sv
// Shared types and helpers for the FIFO read-side word packer.
// Holds the default widths, the FSM state type and the lane keep-mask builder.
package fifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int BYTES_DEF  = 4;
  localparam int MAX_BYTES  = 8;

  typedef enum logic {
    FILL = 1'b0,
    OUT  = 1'b1
  } state_t;

  // Low n lanes set; callers slice the lanes they actually have.
  function automatic logic [MAX_BYTES-1:0] keep_mask(input int unsigned n);
    logic [MAX_BYTES-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      mask[i] = (i < n);
    end
    return mask;
  endfunction

endpackage

// File: rtl/fifo_word_packer.sv
// Drains bytes from fifo_mem and packs BYTES of them little-endian into one word,
// emitted on a valid/ready stream; partial words leave on flush or idle timeout.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int BYTES   = BYTES_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fifo_empty,
  input  logic [DATA_W-1:0]       fifo_dout,
  input  logic                    fifo_underflow,
  output logic                    fifo_rd,
  input  logic                    flush,
  output logic [DATA_W*BYTES-1:0] m_data,
  output logic [BYTES-1:0]        m_keep,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    err_underflow
);

  localparam int CNT_W  = $clog2(BYTES + 1);
  localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t                    r_state;
  logic [CNT_W-1:0]          r_byte_cnt;
  logic                      r_rd_pend;
  logic                      r_flush_req;
  logic [IDLE_W-1:0]         r_idle_cnt;
  logic [DATA_W*BYTES-1:0]   r_m_data;
  logic [BYTES-1:0]          r_m_keep;
  logic                      r_m_valid;
  logic                      r_err;

  logic [CNT_W:0]            w_inflight;
  logic [CNT_W-1:0]          w_cnt_inc;
  logic                      w_rd;
  logic                      w_timeout_hit;
  logic [MAX_BYTES-1:0]      w_keep_full;
  logic                      w_unused_keep;

  // Bytes already held plus the one still in flight must leave room in the word.
  assign w_inflight    = {1'b0, r_byte_cnt} + {{CNT_W{1'b0}}, r_rd_pend};
  assign w_cnt_inc     = r_byte_cnt + CNT_W'(1);
  assign w_rd          = !rst && (r_state == FILL) && !fifo_empty && !r_flush_req
                         && (w_inflight < (CNT_W+1)'(BYTES));
  assign w_timeout_hit = (TIMEOUT != 0) && (r_idle_cnt == IDLE_W'(TIMEOUT));
  assign w_keep_full   = keep_mask(32'(r_byte_cnt));
  assign w_unused_keep = &{1'b0, w_keep_full};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= FILL;
      r_byte_cnt  <= '0;
      r_rd_pend   <= 1'b0;
      r_flush_req <= 1'b0;
      r_idle_cnt  <= '0;
      r_m_data    <= '0;
      r_m_keep    <= '0;
      r_m_valid   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_rd_pend <= w_rd;
      if (flush || w_timeout_hit) begin
        r_flush_req <= 1'b1;
      end

      case (r_state)
        FILL: begin
          if (r_rd_pend) begin
            if (fifo_underflow) begin
              r_err <= 1'b1;
            end else begin
              for (int i = 0; i < BYTES; i++) begin
                if (r_byte_cnt == CNT_W'(i)) begin
                  r_m_data[i*DATA_W +: DATA_W] <= fifo_dout;
                end
              end
              r_byte_cnt <= w_cnt_inc;
              r_idle_cnt <= '0;
              // A full word takes priority over any flush arriving alongside it.
              if (w_cnt_inc == CNT_W'(BYTES)) begin
                r_state     <= OUT;
                r_m_valid   <= 1'b1;
                r_m_keep    <= '1;
                r_flush_req <= 1'b0;
              end
            end
          end else if (r_flush_req) begin
            r_flush_req <= 1'b0;
            if (r_byte_cnt != '0) begin
              r_state    <= OUT;
              r_m_valid  <= 1'b1;
              r_m_keep   <= w_keep_full[BYTES-1:0];
              r_idle_cnt <= '0;
            end
          end else if ((r_byte_cnt != '0) && fifo_empty
                       && (r_idle_cnt < IDLE_W'(TIMEOUT))) begin
            r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
          end
        end

        OUT: begin
          if (r_m_valid && m_ready) begin
            r_state    <= FILL;
            r_byte_cnt <= '0;
            r_m_data   <= '0;
            r_m_keep   <= '0;
            r_m_valid  <= 1'b0;
            r_idle_cnt <= '0;
          end
        end

        default: r_state <= FILL;
      endcase
    end
  end

  assign fifo_rd       = w_rd;
  assign m_data        = r_m_data;
  assign m_keep        = r_m_keep;
  assign m_valid       = r_m_valid;
  assign err_underflow = r_err;

endmodule
